tm1638_slave_emu: RTL and testbench
===================================

# tm1638_slave_emu

Cycle-accurate responder for the TM1638 three-wire bus (STB, CLK, DIO) that acts as the chip end of the link. It samples the frames a TM1638 master sends, decodes the data, address and display-control commands, and holds the 16-byte display RAM plus the display on/brightness state. On a key-read command it drives a 32-bit key-scan snapshot back on DIO. It serves as the synthesizable bus-functional partner for the existing LED/KEY driver in loopback benches, and as a stand-in panel on boards without a TM1638 fitted.

## Interface
- C_SYNC_N, 2: synchronizer flop stages on STB_i, SCLK_i and DIO_i (minimum 2).
- CK_i  in  1  system clock; all logic on its rising edge.
- RST_i  in  1  synchronous, active-high reset.
- STB_i  in  1  bus strobe, active low; frames the transfer.
- SCLK_i  in  1  bus clock from the master; idles high.
- DIO_i  in  1  bus data in, LSB first.
- DIO_o  out  1  bus data out during key read.
- DIO_OE_o  out  1  DIO output enable; the top level builds the tristate from DIO_o and DIO_OE_o.
- KEY_SCAN_i  in  32  key bytes returned on read; byte k is [8k+:8], byte 0 is sent first.
- DISP_RAM_o  out  128  display RAM; address n is [8n+:8].
- DISP_ON_o  out  1  display-on flag (control bit 3).
- BRIGHT_o  out  3  brightness (control bits 2:0).
- WR_STB_o  out  1  one-CK pulse per RAM byte written.
- WR_ADR_o  out  4  address of the byte written; valid with WR_STB_o.
- KEY_RD_o  out  1  one-CK pulse when KEY_SCAN_i is snapshotted.
- FRAME_ERR_o  out  1  one-CK pulse when STB rises with a partial byte pending.

## Operation
- **Input conditioning:** STB_i, SCLK_i and DIO_i each pass through C_SYNC_N flops, plus one history flop for edge detection. A bit is taken on each SCLK rising edge while synchronized STB is low. Bits shift in LSB first, and a 3-bit counter marks byte completion on the 8th edge.
- **States:**
  - IDLE
  - CMD
  - WDATA
  - RDATA
  - IGNORE
- **Leaving IDLE:** IDLE exits only on a synchronized STB falling edge, to CMD with the bit counter cleared.
- **Command decode (CMD byte complete):**
  - 01xxxxxx, data command: bit 2 sets the fixed-address flag (1 = fixed, 0 = auto-increment). If bit 1 = 1, capture KEY_SCAN_i, pulse KEY_RD_o and go to RDATA. Otherwise go to IGNORE.
  - 10xxxxxx, display control: DISP_ON_o <= bit 3, BRIGHT_o <= bits 2:0, go to IGNORE.
  - 11xxxxxx, address command: ADR <= bits 3:0, go to WDATA.
  - 00xxxxxx: no effect, go to IGNORE.
- **WDATA:** each completed byte is written to RAM[ADR] with WR_STB_o/WR_ADR_o. In auto-increment mode ADR then increments, wrapping 15 -> 0. In fixed mode ADR holds.
- **RDATA:**
  - DIO_OE_o rises on the first SCLK falling edge in RDATA.
  - On each SCLK falling edge, DIO_o <= snapshot[r], where r is the count of SCLK rising edges seen so far in RDATA.
  - After 32 bits, DIO_o = 0 for any further clocks.
- **IGNORE:** all SCLK edges are discarded until STB rises.
- **STB rising edge, any state:** go to IDLE, DIO_OE_o <= 0 and DIO_o <= 0. If the bit counter is non-zero, pulse FRAME_ERR_o and discard the partial byte.
- **Simultaneous edges:** if an STB rise and an SCLK rise are detected in the same CK, the STB rise wins and the SCLK edge is dropped.
- **Persistence:** the fixed-address flag, DISP_ON_o, BRIGHT_o and the RAM persist across frames until rewritten or reset.
- **Reset:**
  - State = IDLE.
  - All RAM bytes = 0, ADR = 0, auto-increment mode.
  - DISP_ON_o = 0, BRIGHT_o = 0.
  - DIO_o = 0, DIO_OE_o = 0, all pulses = 0.
  - The synchronizer and history flops load 1 (idle-high STB/SCLK). If STB_i is still low after reset, no frame starts until STB is seen high and then falling.

## Timing
- Pin-to-detect latency: C_SYNC_N+1 CK from a pin edge to the CK in which the edge is acted on.
- Outputs are registered and visible 1 CK after the detect cycle: DISP_RAM_o updates in the same cycle WR_STB_o is high, and DISP_ON_o/BRIGHT_o update 1 CK after the detect.
- DIO_o/DIO_OE_o change C_SYNC_N+2 CK after the SCLK_i pin falling edge.
- Master constraint: each SCLK phase must be at least C_SYNC_N+3 CK. At CK = 48 MHz and SCLK = 1 MHz (24 CK per phase) this is met with margin.
- KEY_SCAN_i is sampled only in the KEY_RD_o cycle; later changes do not affect the frame in progress.

## Test plan
- **Auto-increment write:** 0x40 frame, then 0xC0 + bytes 0x3F,0x06,0x5B -> RAM[0..2] = 3F,06,5B; WR_STB_o pulses 3× with WR_ADR_o 0,1,2.
- **Fixed mode and wrap:**
  - 0x44, then 0xCF + 0x11,0x22 -> RAM[15] = 0x22, two pulses both at WR_ADR_o 15.
  - 0x40, then 0xCF + 0xAA,0xBB -> RAM[15] = 0xAA, RAM[0] = 0xBB.
- **Control:** frame 0x8A -> DISP_ON_o = 1, BRIGHT_o = 2; RAM unchanged, no WR_STB_o.
- **Key read:** KEY_SCAN_i = 0x80402001, command 0x42, 32 read clocks -> KEY_RD_o pulses once; master samples bytes 01,20,40,80; DIO_OE_o drops within C_SYNC_N+2 CK of the STB pin rising. A 5th byte reads 0x00.
- **Error and abort:**
  - STB rises after 5 bits of a data byte -> FRAME_ERR_o pulses once, RAM unchanged.
  - STB rise coincident with an SCLK rise -> that bit is ignored.
- **Reset mid-frame:** assert RST_i during WDATA with STB low -> all outputs return to reset values. Clocks before the next STB rise-then-fall cause no write.

Source files
------------

// File: rtl/tm1638_slave_emu_if.sv
// tm1638_slave_emu_if: TM1638 three-wire bus pins (STB, SCLK, DIO split into in/out/enable)
interface tm1638_slave_emu_if;
   logic STB_i;
   logic SCLK_i;
   logic DIO_i;
   logic DIO_o;
   logic DIO_OE_o;
   modport master (output STB_i, output SCLK_i, output DIO_i, input DIO_o, input DIO_OE_o);
   modport slave (input STB_i, input SCLK_i, input DIO_i, output DIO_o, output DIO_OE_o);
endinterface

// File: rtl/tm1638_slave_emu.sv
// tm1638_slave_emu: chip-side TM1638 responder holding display RAM and control state,
// returning a snapshotted 32-bit key scan on read commands.
module tm1638_slave_emu #(
   parameter int C_SYNC_N = 2
) (
   input  logic                CK_i,
   input  logic                RST_i,
   tm1638_slave_emu_if.slave   bus,
   input  logic [31:0]         KEY_SCAN_i,
   output logic [127:0]        DISP_RAM_o,
   output logic                DISP_ON_o,
   output logic [2:0]          BRIGHT_o,
   output logic                WR_STB_o,
   output logic [3:0]          WR_ADR_o,
   output logic                KEY_RD_o,
   output logic                FRAME_ERR_o
);
   typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;
   state_t state_q, state_d;
   logic [C_SYNC_N-1:0] stb_sync_q, sclk_sync_q, dio_sync_q, vld_q;
   logic stb_h_q, sclk_h_q, armed_q;
   logic stb_s, sclk_s, dio_s, stb_rise, stb_fall, sclk_rise, sclk_fall;
   logic [7:0] rx_byte;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [3:0] adr_q, adr_d, wr_adr_q, wr_adr_d;
   logic fixed_q, fixed_d, disp_on_q, disp_on_d;
   logic [2:0] bright_q, bright_d;
   logic [127:0] ram_q, ram_d;
   logic [31:0] snap_q, snap_d;
   logic [5:0] rd_cnt_q, rd_cnt_d;
   logic dio_q, dio_d, dio_oe_q, dio_oe_d;
   logic wr_stb_q, wr_stb_d, key_rd_q, key_rd_d, frame_err_q, frame_err_d;

   assign stb_s = stb_sync_q[C_SYNC_N-1];
   assign sclk_s = sclk_sync_q[C_SYNC_N-1];
   assign dio_s = dio_sync_q[C_SYNC_N-1];
   assign stb_rise = ~stb_h_q & stb_s;
   assign stb_fall = stb_h_q & ~stb_s;
   assign sclk_rise = ~sclk_h_q & sclk_s & ~stb_s;
   assign sclk_fall = sclk_h_q & ~sclk_s & ~stb_s;
   assign rx_byte = {dio_s, shift_q};

   // armed_q blocks a frame until STB has been genuinely sampled high after reset
   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         stb_sync_q <= '1;
         sclk_sync_q <= '1;
         dio_sync_q <= '1;
         vld_q <= '0;
         stb_h_q <= 1'b1;
         sclk_h_q <= 1'b1;
         armed_q <= 1'b0;
      end else begin
         stb_sync_q <= {stb_sync_q[C_SYNC_N-2:0], bus.STB_i};
         sclk_sync_q <= {sclk_sync_q[C_SYNC_N-2:0], bus.SCLK_i};
         dio_sync_q <= {dio_sync_q[C_SYNC_N-2:0], bus.DIO_i};
         vld_q <= {vld_q[C_SYNC_N-2:0], 1'b1};
         stb_h_q <= stb_s;
         sclk_h_q <= sclk_s;
         armed_q <= armed_q | (vld_q[C_SYNC_N-1] & stb_s);
      end
   end

   always_ff @(posedge CK_i) begin
      if (RST_i) begin
         state_q <= IDLE;
         bit_cnt_q <= '0;
         shift_q <= '0;
         adr_q <= '0;
         fixed_q <= 1'b0;
         disp_on_q <= 1'b0;
         bright_q <= '0;
         ram_q <= '0;
         snap_q <= '0;
         rd_cnt_q <= '0;
         dio_q <= 1'b0;
         dio_oe_q <= 1'b0;
         wr_stb_q <= 1'b0;
         wr_adr_q <= '0;
         key_rd_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q <= shift_d;
         adr_q <= adr_d;
         fixed_q <= fixed_d;
         disp_on_q <= disp_on_d;
         bright_q <= bright_d;
         ram_q <= ram_d;
         snap_q <= snap_d;
         rd_cnt_q <= rd_cnt_d;
         dio_q <= dio_d;
         dio_oe_q <= dio_oe_d;
         wr_stb_q <= wr_stb_d;
         wr_adr_q <= wr_adr_d;
         key_rd_q <= key_rd_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d = shift_q;
      adr_d = adr_q;
      fixed_d = fixed_q;
      disp_on_d = disp_on_q;
      bright_d = bright_q;
      ram_d = ram_q;
      snap_d = snap_q;
      rd_cnt_d = rd_cnt_q;
      dio_d = dio_q;
      dio_oe_d = dio_oe_q;
      wr_stb_d = 1'b0;
      wr_adr_d = wr_adr_q;
      key_rd_d = 1'b0;
      frame_err_d = 1'b0;
      if (stb_rise) begin
         state_d = IDLE;
         dio_d = 1'b0;
         dio_oe_d = 1'b0;
         frame_err_d = |bit_cnt_q;
         bit_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE: if (stb_fall && armed_q) begin
               state_d = CMD;
               bit_cnt_d = '0;
            end
            CMD: if (sclk_rise) begin
               shift_d = rx_byte[7:1];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (&bit_cnt_q) begin
                  state_d = IGNORE;
                  if (rx_byte[7:6] == 2'b01) begin
                     fixed_d = rx_byte[2];
                     if (rx_byte[1]) begin
                        state_d = RDATA;
                        snap_d = KEY_SCAN_i;
                        key_rd_d = 1'b1;
                        rd_cnt_d = '0;
                     end
                  end else if (rx_byte[7:6] == 2'b10) begin
                     disp_on_d = rx_byte[3];
                     bright_d = rx_byte[2:0];
                  end else if (rx_byte[7]) begin
                     adr_d = rx_byte[3:0];
                     state_d = WDATA;
                  end
               end
            end
            WDATA: if (sclk_rise) begin
               shift_d = rx_byte[7:1];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (&bit_cnt_q) begin
                  ram_d[{adr_q, 3'b000} +: 8] = rx_byte;
                  wr_stb_d = 1'b1;
                  wr_adr_d = adr_q;
                  adr_d = fixed_q ? adr_q : adr_q + 4'd1;
               end
            end
            // rd_cnt_q saturates at 32 so the line reads 0 beyond the snapshot
            RDATA: begin
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  rd_cnt_d = rd_cnt_q + {5'd0, ~rd_cnt_q[5]};
               end
               if (sclk_fall) begin
                  dio_oe_d = 1'b1;
                  dio_d = ~rd_cnt_q[5] & snap_q[rd_cnt_q[4:0]];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.DIO_o = dio_q;
   assign bus.DIO_OE_o = dio_oe_q;
   assign DISP_RAM_o = ram_q;
   assign DISP_ON_o = disp_on_q;
   assign BRIGHT_o = bright_q;
   assign WR_STB_o = wr_stb_q;
   assign WR_ADR_o = wr_adr_q;
   assign KEY_RD_o = key_rd_q;
   assign FRAME_ERR_o = frame_err_q;
endmodule

// File: tb/tb_tm1638_slave_emu.sv
// tb_tm1638_slave_emu: directed plus randomized TM1638 master frames checked against
// a byte-level model of RAM, control state, write pulses, key reads and frame errors.
module tb_tm1638_slave_emu;
   localparam int PH = 8;
   localparam int NS = 2;
   typedef logic [7:0] bq_t[$];
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   tm1638_slave_emu_if bus();
   logic [31:0] key_scan;
   logic [127:0] disp_ram;
   logic disp_on, wr_stb, key_rd, frame_err;
   logic [2:0] bright;
   logic [3:0] wr_adr;
   tm1638_slave_emu #(.C_SYNC_N(NS)) dut (
      .CK_i(clk), .RST_i(rst), .bus(bus), .KEY_SCAN_i(key_scan),
      .DISP_RAM_o(disp_ram), .DISP_ON_o(disp_on), .BRIGHT_o(bright),
      .WR_STB_o(wr_stb), .WR_ADR_o(wr_adr), .KEY_RD_o(key_rd), .FRAME_ERR_o(frame_err)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] m_ram[16];
   logic m_fixed, m_on;
   logic [2:0] m_bri;
   logic [3:0] exp_wa[$], obs_wa[$];
   logic [7:0] exp_wd[$], obs_wd[$];
   int exp_key = 0, obs_key = 0, exp_ferr = 0, obs_ferr = 0;
   bq_t tx_q;

   always @(negedge clk) if (!rst) begin
      if (wr_stb) begin
         obs_wa.push_back(wr_adr);
         obs_wd.push_back(disp_ram[{wr_adr, 3'b000} +: 8]);
      end
      if (key_rd) obs_key++;
      if (frame_err) obs_ferr++;
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [127:0] m_pack();
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_ram[i];
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_ram[i] = 8'h00;
      m_fixed = 1'b0;
      m_on = 1'b0;
      m_bri = 3'd0;
   endtask

   // Frame semantics at byte level: first byte is the command, the rest are RAM data
   task automatic model_apply(input bq_t q);
      logic [7:0] c;
      logic [3:0] a;
      c = q[0];
      if (c[7:6] == 2'b01) m_fixed = c[2];
      if (c[7:6] == 2'b10) begin
         m_on = c[3];
         m_bri = c[2:0];
      end
      if (c[7:6] == 2'b11) begin
         a = c[3:0];
         for (int i = 1; i < q.size(); i++) begin
            m_ram[a] = q[i];
            exp_wa.push_back(a);
            exp_wd.push_back(q[i]);
            if (!m_fixed) a = 4'((a + 1) % 16);
         end
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_bits(input logic [7:0] b, input int nb);
      for (int i = 0; i < nb; i++) begin
         bus.SCLK_i = 1'b0;
         bus.DIO_i = b[i];
         cyc(PH);
         bus.SCLK_i = 1'b1;
         cyc(PH);
      end
   endtask

   task automatic frame();
      bus.STB_i = 1'b0;
      cyc(PH);
      foreach (tx_q[i]) send_bits(tx_q[i], 8);
      bus.STB_i = 1'b1;
      cyc(2 * PH);
      model_apply(tx_q);
   endtask

   task automatic read_frame(input logic [7:0] cmd, input int nbytes, input bit change_key);
      logic [31:0] snap;
      logic [7:0] rb, e;
      bus.STB_i = 1'b0;
      cyc(PH);
      snap = key_scan;
      send_bits(cmd, 8);
      exp_key++;
      m_fixed = cmd[2];
      bus.DIO_i = 1'b0;
      for (int k = 0; k < nbytes; k++) begin
         for (int i = 0; i < 8; i++) begin
            bus.SCLK_i = 1'b0;
            cyc(PH);
            rb[i] = bus.DIO_o;
            if (i == 0) chk("rd_oe", 128'(bus.DIO_OE_o), 128'(1'b1));
            bus.SCLK_i = 1'b1;
            cyc(PH);
         end
         e = (k < 4) ? snap[k*8 +: 8] : 8'h00;
         chk($sformatf("rd_byte%0d", k), 128'(rb), 128'(e));
         if (k == 0 && change_key) key_scan = $urandom;
      end
      bus.STB_i = 1'b1;
      cyc(NS + 2);
      chk("rd_oe_drop", 128'(bus.DIO_OE_o), 128'(1'b0));
      chk("rd_dio_drop", 128'(bus.DIO_o), 128'(1'b0));
      cyc(2 * PH);
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_ram"}, disp_ram, m_pack());
      chk({tag, "_on"}, 128'(disp_on), 128'(m_on));
      chk({tag, "_bri"}, 128'(bright), 128'(m_bri));
      chk({tag, "_nwr"}, 128'(obs_wa.size()), 128'(exp_wa.size()));
      for (int i = 0; i < obs_wa.size() && i < exp_wa.size(); i++) begin
         chk({tag, "_wadr"}, 128'(obs_wa[i]), 128'(exp_wa[i]));
         chk({tag, "_wdat"}, 128'(obs_wd[i]), 128'(exp_wd[i]));
      end
      chk({tag, "_nkey"}, 128'(obs_key), 128'(exp_key));
      chk({tag, "_nferr"}, 128'(obs_ferr), 128'(exp_ferr));
      obs_wa.delete();
      obs_wd.delete();
      exp_wa.delete();
      exp_wd.delete();
   endtask

   initial begin
      bus.STB_i = 1'b1;
      bus.SCLK_i = 1'b1;
      bus.DIO_i = 1'b0;
      key_scan = 32'h0;
      model_reset();
      cyc(5);
      chk("rst_ram", disp_ram, 128'h0);
      chk("rst_dio", 128'({bus.DIO_o, bus.DIO_OE_o}), 128'(2'b00));
      chk("rst_pulses", 128'({wr_stb, key_rd, frame_err}), 128'(3'b000));
      rst = 1'b0;
      cyc(10);
      check_all("reset");
      tx_q = {8'h40};
      frame();
      tx_q = {8'hC0, 8'h3F, 8'h06, 8'h5B};
      frame();
      chk("auto_ram012", 128'(disp_ram[23:0]), 128'(24'h5B063F));
      check_all("auto");
      tx_q = {8'h44};
      frame();
      tx_q = {8'hCF, 8'h11, 8'h22};
      frame();
      chk("fixed_ram15", 128'(disp_ram[127:120]), 128'(8'h22));
      check_all("fixed");
      tx_q = {8'h40};
      frame();
      tx_q = {8'hCF, 8'hAA, 8'hBB};
      frame();
      chk("wrap_ram15_0", 128'({disp_ram[127:120], disp_ram[7:0]}), 128'(16'hAABB));
      check_all("wrap");
      tx_q = {8'h8A};
      frame();
      chk("ctrl", 128'({disp_on, bright}), 128'(4'b1010));
      check_all("ctrl");
      key_scan = 32'h80402001;
      read_frame(8'h42, 5, 1'b1);
      check_all("keyrd");
      bus.STB_i = 1'b0;
      cyc(PH);
      send_bits(8'hC4, 8);
      send_bits(8'h99, 5);
      bus.STB_i = 1'b1;
      cyc(2 * PH);
      exp_ferr++;
      check_all("partial");
      bus.STB_i = 1'b0;
      cyc(PH);
      send_bits(8'hC7, 8);
      send_bits(8'h5A, 7);
      bus.SCLK_i = 1'b0;
      bus.DIO_i = 1'b0;
      cyc(PH);
      bus.SCLK_i = 1'b1;
      bus.STB_i = 1'b1;
      cyc(2 * PH);
      exp_ferr++;
      check_all("coincident");
      for (int it = 0; it < 24; it++) begin
         case ($urandom_range(0, 4))
            0: begin
               tx_q = {{2'b01, 3'($urandom), 1'($urandom), 1'b0, 1'($urandom)}};
               frame();
            end
            1: begin
               tx_q = {{2'b11, 2'($urandom), 4'($urandom)}};
               for (int j = $urandom_range(1, 5); j > 0; j--) tx_q.push_back(8'($urandom));
               frame();
            end
            2: begin
               tx_q = {{2'b10, 2'($urandom), 4'($urandom)}};
               frame();
            end
            3: begin
               key_scan = $urandom;
               read_frame({2'b01, 3'($urandom), 1'($urandom), 1'b1, 1'($urandom)}, 4, 1'b0);
            end
            default: begin
               tx_q = {{2'b00, 6'($urandom)}};
               frame();
            end
         endcase
         check_all($sformatf("rnd%0d", it));
      end
      bus.STB_i = 1'b0;
      cyc(PH);
      send_bits(8'hC5, 8);
      send_bits(8'hE7, 8);
      m_ram[5] = 8'hE7;
      exp_wa.push_back(4'd5);
      exp_wd.push_back(8'hE7);
      send_bits(8'h0F, 3);
      check_all("pre_rst");
      rst = 1'b1;
      cyc(3);
      rst = 1'b0;
      model_reset();
      cyc(1);
      chk("mid_rst_ram", disp_ram, 128'h0);
      chk("mid_rst_ctrl", 128'({disp_on, bright}), 128'(4'b0000));
      chk("mid_rst_dio", 128'({bus.DIO_o, bus.DIO_OE_o}), 128'(2'b00));
      send_bits(8'hC0, 8);
      send_bits(8'h33, 8);
      bus.STB_i = 1'b1;
      cyc(2 * PH);
      check_all("post_rst_idle");
      tx_q = {8'hC0, 8'h77, 8'h88};
      frame();
      check_all("post_rst_write");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
